// File: rtl/quire_window_arbiter_pkg.sv
// Shared types for the quire window arbiter.
// Holds the posit<4,0> decoded-product field widths, the decoded beat struct
// carried on every requester lane and the arbiter FSM state type.
package quire_window_arbiter_pkg;

  localparam int unsigned POSIT4_FRAC_W  = 4;
  localparam int unsigned POSIT4_SCALE_W = 4;

  // One decoded posit<4,0> product beat, including window framing.
  typedef struct packed {
    logic                      sign;
    logic                      zero;
    logic                      NaR;
    logic                      sow;
    logic                      eow;
    logic [POSIT4_FRAC_W-1:0]  fraction;
    logic [POSIT4_SCALE_W-1:0] scale;
  } posit4_dec_t;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

endpackage

// File: rtl/quire_window_arbiter_id_fifo.sv
// Small ID FIFO: synchronous write/read, asynchronous clear.
// Ports:
//   clk, rst_n         clock, asynchronous active-low clear
//   push_i / data_i    write one entry (ignored while full unless popping)
//   pop_i / data_o     drop the head entry; data_o always shows the head
//   full_o, empty_o    occupancy flags
//   count_o            number of stored entries
module quire_window_arbiter_id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/quire_window_arbiter.sv
// Shares one quire_4_0 accumulator between NUM_REQ decoded-product streams.
// A requester owns the quire for a whole window (sow..eow); its beats are
// forwarded unchanged except that the first beat always carries sow. The owner
// of each closed window is queued so quire results leave tagged with their ID.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_*_i / req_rtr_o           per-requester beat streams (packed, 4 bits/lane)
//   q_*_o / q_rtr_i               beat stream to the quire
//   res_rts_i/res_eow_i/res_rtr_o quire result handshake
//   res_rts_o/res_rtr_i/res_id_o  tagged result handshake towards downstream
//   err_sow_o                     sticky sow framing error
//   busy_o                        high while a window is granted
module quire_window_arbiter
  import quire_window_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ID_W          = $clog2(NUM_REQ),
  parameter int unsigned ID_FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_rts_i,
  output logic [NUM_REQ-1:0]                  req_rtr_o,
  input  logic [NUM_REQ-1:0]                  req_sow_i,
  input  logic [NUM_REQ-1:0]                  req_eow_i,
  input  logic [NUM_REQ-1:0]                  req_sign_i,
  input  logic [NUM_REQ-1:0]                  req_zero_i,
  input  logic [NUM_REQ-1:0]                  req_NaR_i,
  input  logic [POSIT4_FRAC_W*NUM_REQ-1:0]    req_fraction_i,
  input  logic [POSIT4_SCALE_W*NUM_REQ-1:0]   req_scale_i,
  input  logic                                q_rtr_i,
  output logic                                q_rts_o,
  output logic                                q_sow_o,
  output logic                                q_eow_o,
  output logic                                q_sign_o,
  output logic                                q_zero_o,
  output logic                                q_NaR_o,
  output logic [POSIT4_FRAC_W-1:0]            q_fraction_o,
  output logic [POSIT4_SCALE_W-1:0]           q_scale_o,
  input  logic                                res_rts_i,
  input  logic                                res_eow_i,
  output logic                                res_rtr_o,
  output logic                                res_rts_o,
  input  logic                                res_rtr_i,
  output logic [ID_W-1:0]                     res_id_o,
  output logic                                err_sow_o,
  output logic                                busy_o
);

  localparam int unsigned CntW = $clog2(ID_FIFO_DEPTH + 1);

  // First requester with rts set, searching upward from ptr with wrap.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] rts,
                                               input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && rts[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  posit4_dec_t     req_dec [NUM_REQ];
  posit4_dec_t     sel, q_dec;
  arb_state_e      state_q;
  logic [ID_W-1:0] grant_q, rr_ptr_q, rr_next;
  logic            first_beat_q, err_q;
  logic            locked, beat_fire, win_close;
  logic            fifo_full, fifo_empty, res_pop;
  logic [CntW-1:0] fifo_count;
  logic            unused_fifo_count;

  for (genvar k = 0; k < int'(NUM_REQ); k++) begin : g_unpack
    assign req_dec[k] = {req_sign_i[k], req_zero_i[k], req_NaR_i[k], req_sow_i[k], req_eow_i[k],
                         req_fraction_i[k*POSIT4_FRAC_W +: POSIT4_FRAC_W],
                         req_scale_i[k*POSIT4_SCALE_W +: POSIT4_SCALE_W]};
  end

  assign sel       = req_dec[grant_q];
  assign locked    = (state_q == StLocked);
  assign beat_fire = locked & req_rts_i[grant_q] & q_rtr_i;
  assign win_close = beat_fire & sel.eow;
  assign rr_next   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      first_beat_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Blocking entry while the ID FIFO is full keeps the close-time push safe.
          if (|req_rts_i && !fifo_full) begin
            grant_q      <= rr_pick(req_rts_i, rr_ptr_q);
            first_beat_q <= 1'b1;
            state_q      <= StLocked;
          end
        end
        StLocked: begin
          if (beat_fire) begin
            // Error on a first beat without sow, or a later beat with sow.
            if (first_beat_q ^ sel.sow) begin
              err_q <= 1'b1;
            end
            first_beat_q <= 1'b0;
            if (sel.eow) begin
              rr_ptr_q <= rr_next;
              state_q  <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    q_dec     = '0;
    q_rts_o   = 1'b0;
    req_rtr_o = '0;
    if (locked) begin
      q_dec              = sel;
      q_dec.sow          = sel.sow | first_beat_q;
      q_rts_o            = req_rts_i[grant_q];
      req_rtr_o[grant_q] = q_rtr_i;
    end
  end

  assign q_sow_o      = q_dec.sow;
  assign q_eow_o      = q_dec.eow;
  assign q_sign_o     = q_dec.sign;
  assign q_zero_o     = q_dec.zero;
  assign q_NaR_o      = q_dec.NaR;
  assign q_fraction_o = q_dec.fraction;
  assign q_scale_o    = q_dec.scale;

  assign res_rts_o = res_rts_i & ~fifo_empty;
  assign res_rtr_o = res_rtr_i & ~fifo_empty;
  assign res_pop   = res_rts_i & res_rtr_i & res_eow_i & ~fifo_empty;
  assign err_sow_o = err_q;
  assign busy_o    = locked;

  quire_window_arbiter_id_fifo #(
    .WIDTH(ID_W),
    .DEPTH(ID_FIFO_DEPTH)
  ) u_id_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (win_close),
    .data_i (grant_q),
    .pop_i  (res_pop),
    .data_o (res_id_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;

endmodule

// File: tb/tb_quire_window_arbiter.sv
// Randomized bench for quire_window_arbiter with a queue-based reference model.
module tb_quire_window_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_rts_i, req_rtr_o, req_sow_i, req_eow_i;
  logic [N-1:0]     req_sign_i, req_zero_i, req_NaR_i;
  logic [4*N-1:0]   req_fraction_i, req_scale_i;
  logic             q_rtr_i, q_rts_o, q_sow_o, q_eow_o, q_sign_o, q_zero_o, q_NaR_o;
  logic [3:0]       q_fraction_o, q_scale_o;
  logic             res_rts_i, res_eow_i, res_rtr_o, res_rts_o, res_rtr_i;
  logic [1:0]       res_id_o;
  logic             err_sow_o, busy_o;

  typedef struct packed {
    logic       sign, zero, nar, sow, eow;
    logic [3:0] frac, scale;
  } beat_t;

  // Per-requester beat queues (ring buffers) and model state.
  beat_t       bq [N][256];
  int          bh [N];
  int          bt [N];
  bit          started [N];
  bit          m_locked, m_first, m_err;
  int          m_owner, m_rr;
  int          m_fifo [$];
  int          n_cmp, n_bad;
  int unsigned p_new, p_qrtr, p_stall, p_rtr, p_sowerr;

  quire_window_arbiter #(
    .NUM_REQ(N),
    .ID_W(2),
    .ID_FIFO_DEPTH(D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_rts_i     (req_rts_i),
    .req_rtr_o     (req_rtr_o),
    .req_sow_i     (req_sow_i),
    .req_eow_i     (req_eow_i),
    .req_sign_i    (req_sign_i),
    .req_zero_i    (req_zero_i),
    .req_NaR_i     (req_NaR_i),
    .req_fraction_i(req_fraction_i),
    .req_scale_i   (req_scale_i),
    .q_rtr_i       (q_rtr_i),
    .q_rts_o       (q_rts_o),
    .q_sow_o       (q_sow_o),
    .q_eow_o       (q_eow_o),
    .q_sign_o      (q_sign_o),
    .q_zero_o      (q_zero_o),
    .q_NaR_o       (q_NaR_o),
    .q_fraction_o  (q_fraction_o),
    .q_scale_o     (q_scale_o),
    .res_rts_i     (res_rts_i),
    .res_eow_i     (res_eow_i),
    .res_rtr_o     (res_rtr_o),
    .res_rts_o     (res_rts_o),
    .res_rtr_i     (res_rtr_i),
    .res_id_o      (res_id_o),
    .err_sow_o     (err_sow_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Queue one whole window for requester k; len 0 picks 1..3 beats.
  task automatic add_window(input int k, input int len);
    beat_t b;
    int    n;
    n = (len == 0) ? int'($urandom_range(3, 1)) : len;
    for (int i = 0; i < n; i++) begin
      b.sign  = 1'($urandom);
      b.zero  = 1'($urandom);
      b.nar   = 1'($urandom);
      b.frac  = 4'($urandom);
      b.scale = 4'($urandom);
      b.eow   = (i == n - 1);
      if (i == 0) b.sow = ($urandom_range(99) >= p_sowerr);
      else        b.sow = ($urandom_range(99) < p_sowerr / 2);
      bq[k][bt[k] % 256] = b;
      bt[k]++;
    end
  endtask

  task automatic clear_inputs();
    req_rts_i      = '0;
    req_sow_i      = '0;
    req_eow_i      = '0;
    req_sign_i     = '0;
    req_zero_i     = '0;
    req_NaR_i      = '0;
    req_fraction_i = '0;
    req_scale_i    = '0;
    q_rtr_i        = 1'b0;
    res_rts_i      = 1'b0;
    res_eow_i      = 1'b0;
    res_rtr_i      = 1'b0;
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_first  = 1'b0;
    m_err    = 1'b0;
    m_owner  = 0;
    m_rr     = 0;
    m_fifo.delete();
    for (int k = 0; k < N; k++) begin
      bh[k]      = 0;
      bt[k]      = 0;
      started[k] = 1'b0;
    end
  endtask

  // One clock: drive at negedge, check just after, advance the model for the posedge.
  task automatic step();
    beat_t        b;
    logic [N-1:0] exp_rtr;
    logic [12:0]  obs_b, exp_b;
    bit           fire, pop, full_now, found;
    int           k;
    @(negedge clk);
    if ($urandom_range(99) < p_new) begin
      k = int'($urandom_range(N - 1));
      if (bt[k] - bh[k] < 16) add_window(k, 0);
    end
    for (int r = 0; r < N; r++) begin
      b = (bt[r] != bh[r]) ? bq[r][bh[r] % 256] : '0;
      req_rts_i[r]           = (bt[r] != bh[r]) && !(started[r] && ($urandom_range(99) < p_stall));
      req_sow_i[r]           = b.sow;
      req_eow_i[r]           = b.eow;
      req_sign_i[r]          = b.sign;
      req_zero_i[r]          = b.zero;
      req_NaR_i[r]           = b.nar;
      req_fraction_i[4*r+:4] = b.frac;
      req_scale_i[4*r+:4]    = b.scale;
    end
    q_rtr_i   = ($urandom_range(99) < p_qrtr);
    res_rts_i = ($urandom_range(99) < 60);
    res_eow_i = ($urandom_range(99) < 50);
    res_rtr_i = ($urandom_range(99) < p_rtr);
    #1;
    chk("busy", 32'(busy_o), 32'(m_locked));
    exp_rtr = '0;
    if (m_locked) exp_rtr[m_owner] = q_rtr_i;
    chk("req_rtr", 32'(req_rtr_o), 32'(exp_rtr));
    chk("q_rts", 32'(q_rts_o), 32'(m_locked && req_rts_i[m_owner]));
    if (m_locked && req_rts_i[m_owner]) begin
      b     = bq[m_owner][bh[m_owner] % 256];
      exp_b = {b.sign, b.zero, b.nar, b.sow | m_first, b.eow, b.frac, b.scale};
      obs_b = {q_sign_o, q_zero_o, q_NaR_o, q_sow_o, q_eow_o, q_fraction_o, q_scale_o};
      chk("q_beat", 32'(obs_b), 32'(exp_b));
    end
    chk("res_rts", 32'(res_rts_o), 32'(res_rts_i && m_fifo.size() > 0));
    chk("res_rtr", 32'(res_rtr_o), 32'(res_rtr_i && m_fifo.size() > 0));
    if (m_fifo.size() > 0) chk("res_id", 32'(res_id_o), m_fifo[0]);
    chk("err_sow", 32'(err_sow_o), 32'(m_err));

    full_now = (m_fifo.size() >= D);
    fire     = m_locked && req_rts_i[m_owner] && q_rtr_i;
    pop      = res_rts_i && res_rtr_i && res_eow_i && (m_fifo.size() > 0);
    if (pop) void'(m_fifo.pop_front());
    if (fire) begin
      b = bq[m_owner][bh[m_owner] % 256];
      bh[m_owner]++;
      if (m_first && !b.sow) m_err = 1'b1;
      if (!m_first && b.sow) m_err = 1'b1;
      m_first          = 1'b0;
      started[m_owner] = !b.eow;
      if (b.eow) begin
        m_fifo.push_back(m_owner);
        m_rr     = (m_owner + 1) % N;
        m_locked = 1'b0;
      end
    end else if (!m_locked && req_rts_i != '0 && !full_now) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!found && req_rts_i[(m_rr + i) % N]) begin
          m_owner = (m_rr + i) % N;
          found   = 1'b1;
        end
      end
      m_locked = 1'b1;
      m_first  = 1'b1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    clear_inputs();
    p_new = 0; p_qrtr = 100; p_stall = 0; p_rtr = 0; p_sowerr = 0;

    // Reset state, with inputs that would otherwise open every gate.
    rst_n     = 1'b0;
    req_rts_i = '1;
    q_rtr_i   = 1'b1;
    res_rts_i = 1'b1;
    res_rtr_i = 1'b1;
    #3;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_req_rtr", 32'(req_rtr_o), 0);
    chk("rst_q_rts", 32'(q_rts_o), 0);
    chk("rst_res_rts", 32'(res_rts_o), 0);
    chk("rst_res_rtr", 32'(res_rtr_o), 0);
    chk("rst_err", 32'(err_sow_o), 0);
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Requester 2 alone: 3-beat window, then rr pointer should favour 3.
    add_window(2, 3);
    repeat (5) step();
    chk("solo_id", 32'(res_id_o), 2);
    add_window(0, 2);
    add_window(3, 2);
    repeat (2) step();
    chk("rr_after_2", 32'(req_rtr_o), 32'h8);

    // Mixed random traffic with stalls and framing errors.
    p_new = 40; p_qrtr = 70; p_stall = 20; p_rtr = 70; p_sowerr = 10;
    repeat (1500) step();

    // Results held off: FIFO fills and arbitration must stop.
    p_new = 60; p_qrtr = 90; p_stall = 0; p_rtr = 0;
    repeat (300) step();
    if (m_fifo.size() == D) chk("full_blocks_grant", 32'(busy_o), 0);
    p_rtr = 90;
    repeat (300) step();

    // Asynchronous reset in the middle of a window.
    p_stall = 0; p_qrtr = 60; p_rtr = 80;
    for (int w = 0; w < 500 && !(m_locked && started[m_owner]); w++) step();
    chk("busy_before_rst", 32'(busy_o), 1);
    @(negedge clk);
    res_rts_i = 1'b1;
    res_rtr_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_q_rts", 32'(q_rts_o), 0);
    chk("arst_req_rtr", 32'(req_rtr_o), 0);
    chk("arst_res_rts", 32'(res_rts_o), 0);
    chk("arst_res_rtr", 32'(res_rtr_o), 0);
    chk("arst_err", 32'(err_sow_o), 0);
    model_reset();
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    p_new = 0; p_qrtr = 100; p_sowerr = 0;
    for (int k = 0; k < N; k++) add_window(k, 2);
    repeat (2) step();
    chk("first_grant_after_rst", 32'(req_rtr_o), 32'h1);

    p_new = 40; p_qrtr = 75; p_stall = 15; p_rtr = 70; p_sowerr = 10;
    repeat (500) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
